// File: rtl/matrix_pkg.sv
// Shared constants for the matrix loader: APB register map, CTRL bit
// positions and FSM state encodings.
package matrix_pkg;

  // APB register select
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL register bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  // Load FSM; the encoding is also the STATUS state code
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_loader.sv
// APB slave that buffers a burst of WORDS data words for the matrix
// controller and hands it over with a one-cycle load_done strobe.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   psel/penable/pwrite      APB control from host
//   paddr, pwdata            APB register select and write data
//   pready, prdata, pslverr  APB response (combinational)
//   ctrl_pready, load_en     controller readiness / load phase
//   start_pulse              one-cycle start request to controller
//   load_done                one-cycle burst-complete strobe
//   load_data                buffered burst, word k at [k*DATA_W +: DATA_W]
//   word_cnt                 words captured in current burst
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [1:0]                 paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic                       ctrl_pready,
  input  logic                       load_en,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic                       start_pulse,
  output logic                       load_done,
  output logic [WORDS*DATA_W-1:0]    load_data,
  output logic [$clog2(WORDS)-1:0]   word_cnt
);

  localparam int unsigned CNT_W = $clog2(WORDS);

  state_t state;
  logic   access;
  logic   accept;
  logic   is_data_wr;
  logic   is_ctrl_wr;

  // APB decode: ready, accept and error/read-data terms
  always_comb begin
    access     = psel & penable;
    is_data_wr = pwrite && (paddr == ADDR_DATA);
    is_ctrl_wr = pwrite && (paddr == ADDR_CTRL);
    pready     = ctrl_pready;
    // DATA writes outside IDLE wait for an open FILL window; in IDLE they
    // complete immediately with an error instead of stalling forever.
    if (is_data_wr && (state != ST_IDLE)) begin
      pready = ctrl_pready & load_en & (state == ST_FILL);
    end
    accept  = access & pready;
    pslverr = 1'b0;
    prdata  = '0;
    if (accept) begin
      pslverr = (paddr == ADDR_RSVD) || (is_data_wr && (state == ST_IDLE));
      if (!pwrite && (paddr == ADDR_STATUS)) begin
        prdata = DATA_W'({word_cnt, state});
      end
    end
  end

  // Load FSM, burst buffer and controller strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      start_pulse <= 1'b0;
      load_done   <= 1'b0;
      load_data   <= '0;
    end else begin
      start_pulse <= 1'b0;
      load_done   <= 1'b0;
      if (state == ST_DONE) begin
        state <= ST_FILL;
      end
      if (accept && is_ctrl_wr) begin
        // abort wins over start and may override the DONE->FILL step
        if (pwdata[CTRL_ABORT_BIT]) begin
          state    <= ST_IDLE;
          word_cnt <= '0;
        end else if (pwdata[CTRL_START_BIT] && (state == ST_IDLE)) begin
          state       <= ST_FILL;
          word_cnt    <= '0;
          start_pulse <= 1'b1;
        end
      end else if (accept && is_data_wr && (state == ST_FILL)) begin
        load_data[word_cnt*DATA_W +: DATA_W] <= pwdata;
        if (word_cnt == CNT_W'(WORDS - 1)) begin
          word_cnt  <= '0;
          state     <= ST_DONE;
          load_done <= 1'b1;
        end else begin
          word_cnt <= word_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
